adc_avg_bcd: RTL and testbench
==============================

# adc_avg_bcd

Downstream consumer of the serial ADC receiver. Captures each 12-bit sample on the receiver's done tick and block-averages 2^AVG_LOG2 samples. Converts the average to 4-digit BCD for the display path. Releases the receiver's wait state through the `temp_finish`/`En_temp` handshake, which back-pressures acquisition until processing completes.

## Interface
Parameters:
- `DATA_W`, 12: sample width. Fixed for the 4-digit BCD range, max 4095.
- `AVG_LOG2`, 3: log2 of the samples averaged per result. Legal range 0..4.

Ports:
- `SCLK` in 1: system clock. Same clock as the receiver.
- `reset` in 1: asynchronous, active-high reset.
- `rx_done_tick` in 1: one-cycle pulse from the receiver; `data_in` is valid in that cycle.
- `data_in` in DATA_W: received sample.
- `En_temp` in 1: receiver status. Low while the receiver waits for `temp_finish`.
- `temp_finish` out 1: release to the receiver.
- `avg_out` out DATA_W: last averaged value.
- `bcd_out` out 16: `avg_out` in BCD, thousands in [15:12].
- `valid_tick` out 1: one-cycle pulse when `avg_out`/`bcd_out` update.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky error flag.

## Operation
- State machine states: IDLE, CONV, ACK.
- IDLE, `rx_done_tick`=1:
  - Compute `acc_next = acc + data_in`. The accumulator is DATA_W+AVG_LOG2 bits wide and cannot overflow.
  - If `cnt == 2^AVG_LOG2-1`: latch `avg = acc_next >> AVG_LOG2` (floor, no rounding), clear `acc` and `cnt`, start the BCD converter, go to CONV.
  - Otherwise: `acc <= acc_next`, `cnt <= cnt+1`, go to ACK.
- CONV: iterative double-dabble, one bit per cycle, DATA_W iterations.
  - On the last iteration, register `avg_out` and `bcd_out`, pulse `valid_tick`, go to ACK.
- ACK: `temp_finish`=1 (registered Moore output).
  - Leave to IDLE at the first edge where `En_temp`=1.
  - `temp_finish` stays high indefinitely while `En_temp`=0.
- `rx_done_tick` outside IDLE: the sample is dropped, `overrun` is set, and the FSM is unaffected. `overrun` clears only on reset.
- Reset values: `temp_finish`, `valid_tick`, `busy`, `overrun` = 0; `avg_out`, `bcd_out` = 0. Internally `acc`, `cnt` and the converter are cleared and the state is IDLE.
- Reset mid-operation (CONV or ACK):
  - All partial results are discarded and outputs keep no stale update.
  - The receiver is reset by the same `reset`, so the handshake restarts clean.

## Timing
- Edge k samples `rx_done_tick`=1 in IDLE.
- Non-final sample: `temp_finish` is high in the cycle after edge k.
- Final sample:
  - CONV occupies edges k+1..k+DATA_W.
  - `valid_tick` and the new `bcd_out`/`avg_out` appear after edge k+DATA_W.
  - `temp_finish` rises in that same cycle.
- Receiver sequence: it enters its wait state on edge k. It returns to idle on the first edge with `temp_finish`=1; its `En_temp` goes high combinationally in that cycle, so ACK exits on the same edge.
- Minimum spacing between accepted samples: 2 cycles for non-final samples, DATA_W+2 cycles for final samples.

## Configuration
- `ADC_AVG_EN` defined: averaging as above with `AVG_LOG2`.
- `ADC_AVG_EN` undefined:
  - Every sample is final: `AVG_LOG2` is ignored, `avg_out` equals `data_in`, and every sample goes through CONV.
  - The `acc`/`cnt` logic is not synthesized.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE, CONV, ACK);
  - `DATA_W`;
  - `BCD_DIGITS`=4;
  - the BCD width 16.
- One sub-module, `bin2bcd_seq`:
  - ports: start pulse, DATA_W binary in, 16-bit BCD out, done pulse;
  - add-3-then-shift per cycle, DATA_W cycles, also reset by `reset`;
  - the top FSM waits on its done pulse.

## Test plan
- `ADC_AVG_EN`, AVG_LOG2=2, samples 100, 200, 300, 400 → `avg_out`=250 and `bcd_out`=0x0250 after the 4th sample. `valid_tick` pulses once; `temp_finish` pulses after each sample.
- `ADC_AVG_EN`, AVG_LOG2=2, four samples of 4095 → `avg_out`=4095, `bcd_out`=0x4095. Then 1, 1, 1, 2 → `avg_out`=1 (floor), `bcd_out`=0x0001.
- No macro, single sample 1234 at edge k → `bcd_out`=0x1234 and `valid_tick` after edge k+12; `temp_finish` high in that cycle.
- Hold `En_temp`=0 for 5 cycles in ACK → `temp_finish` stays high 5+ cycles. It drops after the first edge with `En_temp`=1 and `busy` falls.
- `rx_done_tick` during CONV → `overrun`=1. The result equals that of the undisturbed run and `acc` is unchanged.
- Assert `reset` at CONV cycle 6 → all outputs 0 and state IDLE. No `valid_tick` until the next full sample set.

Source files
------------

// File: rtl/adc_avg_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_bcd_pkg
// Description : Shared constants for the ADC averaging / BCD conversion
//               block: sample width, BCD digit count and width, and the
//               control state encoding (IDLE, CONV, ACK).
// Revision    : 1.0 - initial release
// ============================================================================
package adc_avg_bcd_pkg;

    localparam int c_DATA_W     = 12;
    localparam int c_BCD_DIGITS = 4;
    localparam int c_BCD_W      = 4 * c_BCD_DIGITS;

    localparam int                c_ST_W    = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_CONV = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_ACK  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/adc_avg_bcd_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble binary-to-BCD converter. One input
//               bit is consumed per clock, DATA_W clocks per conversion.
// Ports       : SCLK    - clock
//               reset   - asynchronous active-high reset
//               start   - one-cycle pulse, bin_in is loaded on this edge
//               bin_in  - binary value to convert
//               bcd_out - result of the current iteration; the final BCD
//                         value while done is high
//               done    - high during the cycle whose closing edge performs
//                         the last iteration
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import adc_avg_bcd_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int BCD_W  = c_BCD_W
) (
    input  logic              SCLK,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bin_in,
    output logic [BCD_W-1:0]  bcd_out,
    output logic              done
);

    localparam int                 c_CNT_W = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);

    logic                      r_active;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [DATA_W-1:0]         r_bin;
    logic [BCD_W-1:0]          r_bcd;
    logic [BCD_W-1:0]          w_adj;
    logic [BCD_W+DATA_W-1:0]   w_shift;

    // Add-3 to every digit >= 5, then shift the {bcd, bin} pair left by one.
    // Doing the shift on the concatenation keeps the carry from the binary
    // MSB into the BCD LSB implicit.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < BCD_W / 4; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
        w_shift = {w_adj, r_bin} << 1;
    end

    // Exposing the pre-register value lets the consumer capture the result
    // on the same edge as the last iteration, without an extra cycle.
    assign bcd_out = w_shift[BCD_W+DATA_W-1:DATA_W];
    assign done    = r_active && (r_cnt == c_LAST);

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bin    <= '0;
            r_bcd    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_bin    <= bin_in;
            r_bcd    <= '0;
        end else if (r_active) begin
            r_bcd <= w_shift[BCD_W+DATA_W-1:DATA_W];
            r_bin <= w_shift[DATA_W-1:0];
            r_cnt <= r_cnt + 1'b1;
            if (done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_avg_bcd.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_bcd
// Description : Captures ADC samples on the receiver done tick, block-averages
//               2^AVG_LOG2 of them (floor), converts the average to 4-digit
//               BCD and releases the receiver through temp_finish/En_temp.
//               Build macro ADC_AVG_EN enables averaging; without it every
//               sample is converted and reported individually.
// Ports       : SCLK         - system clock (shared with the receiver)
//               reset        - asynchronous active-high reset
//               rx_done_tick - one-cycle sample strobe, data_in valid
//               data_in      - received sample
//               En_temp      - receiver status, low while it waits
//               temp_finish  - registered release to the receiver
//               avg_out      - last averaged value
//               bcd_out      - avg_out in BCD, thousands in [15:12]
//               valid_tick   - one-cycle pulse when avg_out/bcd_out update
//               busy         - high whenever the FSM is not in IDLE
//               overrun      - sticky: a sample arrived outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module adc_avg_bcd
    import adc_avg_bcd_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int AVG_LOG2 = 3
) (
    input  logic               SCLK,
    input  logic               reset,
    input  logic               rx_done_tick,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               En_temp,
    output logic               temp_finish,
    output logic [DATA_W-1:0]  avg_out,
    output logic [c_BCD_W-1:0] bcd_out,
    output logic               valid_tick,
    output logic               busy,
    output logic               overrun
);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_state_next;
    logic               w_start;
    logic               w_accept;
    logic               w_final;
    logic [DATA_W-1:0]  w_avg_next;
    logic [DATA_W-1:0]  r_avg_pend;
    logic               w_conv_done;
    logic [c_BCD_W-1:0] w_conv_bcd;
    logic               w_conv_fire;
    logic               r_temp_finish;
    logic               r_valid_tick;
    logic               r_overrun;
    logic [DATA_W-1:0]  r_avg_out;
    logic [c_BCD_W-1:0] r_bcd_out;

    assign w_accept = rx_done_tick && (r_state == c_ST_IDLE);

`ifdef ADC_AVG_EN
    // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
    localparam int                 c_ACC_W    = DATA_W + AVG_LOG2;
    localparam int                 c_CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((1 << AVG_LOG2) - 1);

    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] w_acc_next;
    logic [c_CNT_W-1:0] r_cnt;

    assign w_acc_next = r_acc + c_ACC_W'(data_in);
    assign w_final    = (r_cnt == c_CNT_LAST);
    assign w_avg_next = DATA_W'(w_acc_next >> AVG_LOG2);

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_final) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    assign w_final    = 1'b1;
    assign w_avg_next = data_in;
`endif

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .BCD_W  (c_BCD_W)
    ) u_bin2bcd (
        .SCLK    (SCLK),
        .reset   (reset),
        .start   (w_start),
        .bin_in  (w_avg_next),
        .bcd_out (w_conv_bcd),
        .done    (w_conv_done)
    );

    assign w_conv_fire = (r_state == c_ST_CONV) && w_conv_done;

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (rx_done_tick) begin
                    w_start      = w_final;
                    w_state_next = w_final ? c_ST_CONV : c_ST_ACK;
                end
            end
            c_ST_CONV: begin
                if (w_conv_done) begin
                    w_state_next = c_ST_ACK;
                end
            end
            c_ST_ACK: begin
                // The receiver raises En_temp combinationally once it sees
                // temp_finish, so ACK normally lasts a single cycle.
                if (En_temp) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_temp_finish <= 1'b0;
            r_valid_tick  <= 1'b0;
            r_overrun     <= 1'b0;
            r_avg_pend    <= '0;
            r_avg_out     <= '0;
            r_bcd_out     <= '0;
        end else begin
            r_state       <= w_state_next;
            // Moore output decoded from the next state so it is high for
            // exactly the cycles spent in ACK.
            r_temp_finish <= (w_state_next == c_ST_ACK);
            r_valid_tick  <= w_conv_fire;
            if (w_start) begin
                r_avg_pend <= w_avg_next;
            end
            if (w_conv_fire) begin
                r_avg_out <= r_avg_pend;
                r_bcd_out <= w_conv_bcd;
            end
            if (rx_done_tick && (r_state != c_ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign temp_finish = r_temp_finish;
    assign valid_tick  = r_valid_tick;
    assign overrun     = r_overrun;
    assign avg_out     = r_avg_out;
    assign bcd_out     = r_bcd_out;
    assign busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_avg_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_avg_bcd
// Description : Self-checking bench for adc_avg_bcd. Directed and random
//               samples are checked against a reference model that keeps a
//               running sum per block and derives the expected average and
//               BCD digits by integer division. Honours ADC_AVG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_avg_bcd;

    localparam int DATA_W   = 12;
    localparam int AVG_LOG2 = 2;
`ifdef ADC_AVG_EN
    localparam int N_AVG = 1 << AVG_LOG2;
`else
    localparam int N_AVG = 1;
`endif

    logic              SCLK = 1'b0;
    logic              reset;
    logic              rx_done_tick;
    logic [DATA_W-1:0] data_in;
    logic              En_temp;
    logic              temp_finish;
    logic [DATA_W-1:0] avg_out;
    logic [15:0]       bcd_out;
    logic              valid_tick;
    logic              busy;
    logic              overrun;

    logic hold_en;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model state
    int m_sum = 0;
    int m_cnt = 0;

    // Receiver emulation: answers temp_finish immediately unless held.
    assign En_temp = hold_en ? 1'b0 : temp_finish;

    always #5 SCLK = ~SCLK;

    adc_avg_bcd #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) dut (
        .SCLK         (SCLK),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .data_in      (data_in),
        .En_temp      (En_temp),
        .temp_finish  (temp_finish),
        .avg_out      (avg_out),
        .bcd_out      (bcd_out),
        .valid_tick   (valid_tick),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge SCLK);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Adds a sample to the current block; reports whether it completes the
    // block and, if so, the floor average.
    task automatic model_push(input int v, output bit fin, output int avg);
        m_sum += v;
        m_cnt++;
        fin = (m_cnt == N_AVG);
        avg = m_sum / N_AVG;
        if (fin) begin
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    task automatic send_sample(input int v, input int hold, input int intr_at);
        bit fin;
        int exp_avg;
        chk("idle_before_sample", busy, 0);
        model_push(v, fin, exp_avg);
        hold_en      = (hold > 0);
        rx_done_tick = 1'b1;
        data_in      = 12'(v);
        step();
        rx_done_tick = 1'b0;
        if (fin) begin
            for (int i = 1; i <= DATA_W; i++) begin
                chk("conv_valid_low", valid_tick, 0);
                chk("conv_tf_low", temp_finish, 0);
                chk("conv_busy", busy, 1);
                if (i == intr_at) begin
                    rx_done_tick = 1'b1;
                    data_in      = 12'($urandom_range(0, 4095));
                end
                step();
                rx_done_tick = 1'b0;
                if (i == intr_at) chk("overrun_set", overrun, 1);
            end
            chk("valid_tick", valid_tick, 1);
            chk("avg_out", avg_out, exp_avg);
            chk("bcd_out", bcd_out, to_bcd(exp_avg));
        end else begin
            chk("nonfinal_no_valid", valid_tick, 0);
        end
        chk("tf_rise", temp_finish, 1);
        chk("ack_busy", busy, 1);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_tf", temp_finish, 1);
            chk("hold_busy", busy, 1);
            chk("hold_no_valid", valid_tick, 0);
        end
        hold_en = 1'b0;
        step();
        chk("tf_fall", temp_finish, 0);
        chk("busy_fall", busy, 0);
        chk("valid_one_cycle", valid_tick, 0);
    endtask

    initial begin
        int seq[$];
        int vcount;
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        data_in      = '0;
        hold_en      = 1'b0;
        repeat (3) step();
        chk("rst_tf", temp_finish, 0);
        chk("rst_valid", valid_tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_avg", avg_out, 0);
        chk("rst_bcd", bcd_out, 0);
        reset = 1'b0;
        step();

        // Directed samples: mean 250, full scale, floor of 5/4, and 1234.
        seq = '{100, 200, 300, 400, 4095, 4095, 4095, 4095, 1, 1, 1, 2, 1234};
        foreach (seq[i]) send_sample(seq[i], 0, -1);
        // Complete the block containing 1234 so the model starts aligned.
        while (m_cnt != 0) send_sample($urandom_range(0, 4095), 0, -1);

        // Receiver held off for 5 cycles in ACK.
        send_sample(777, 5, -1);
        while (m_cnt != 0) send_sample($urandom_range(0, 4095), 0, -1);

        // Sample arriving during CONV is dropped and flags overrun.
        chk("overrun_clear", overrun, 0);
        while (m_cnt != N_AVG - 1) send_sample($urandom_range(0, 4095), 0, -1);
        send_sample($urandom_range(0, 4095), 0, 3);
        chk("overrun_sticky", overrun, 1);
        for (int i = 0; i < N_AVG; i++) send_sample($urandom_range(0, 4095), 0, -1);

        // Reset asserted at CONV cycle 6.
        while (m_cnt != N_AVG - 1) send_sample($urandom_range(0, 4095), 0, -1);
        rx_done_tick = 1'b1;
        data_in      = 12'(3999);
        step();
        rx_done_tick = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        #1;
        m_sum = 0;
        m_cnt = 0;
        chk("mid_rst_tf", temp_finish, 0);
        chk("mid_rst_valid", valid_tick, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_avg", avg_out, 0);
        chk("mid_rst_bcd", bcd_out, 0);
        step();
        reset  = 1'b0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid_tick) vcount++;
        end
        chk("no_valid_after_rst", vcount, 0);
        chk("avg_still_zero", avg_out, 0);

        // Random traffic with occasional receiver hold-off.
        for (int i = 0; i < 24; i++) begin
            int v;
            case ($urandom_range(0, 5))
                0:       v = 0;
                1:       v = 4095;
                default: v = $urandom_range(0, 4095);
            endcase
            send_sample(v, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
